// File: rtl/hex_scan_if.sv
// hex_scan_if: control inputs and scanned display outputs of hex_scan_display
interface hex_scan_if #(parameter int DIGITS = 4);
  logic enable, load, blank_lz, dp_out, frame_done;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0] dp_in, dig_sel;
  logic [6:0] seg;
  modport master(output enable, load, value, dp_in, blank_lz, input seg, dp_out, dig_sel, frame_done);
  modport slave(input enable, load, value, dp_in, blank_lz, output seg, dp_out, dig_sel, frame_done);
endinterface

// File: rtl/hex_scan_display.sv
// hex_scan_display: double-buffered, time-multiplexed multi-digit seven-segment hex driver
module hex_scan_display #(
  parameter int DIGITS = 4,
  parameter int PRESCALE = 50000,
  parameter int GUARD = 2,
  parameter int ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst_n,
  hex_scan_if.slave bus
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int CW = $clog2(PRESCALE);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);
  localparam logic [CW-1:0] CMAX = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CGRD = CW'(GUARD);
  localparam logic INV = ACTIVE_LOW != 0;
  localparam logic [15:0][6:0] LUT = {7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
                                      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F};
  logic [4*DIGITS-1:0] p_val, a_val, sh;
  logic [DIGITS-1:0] p_dp, a_dp, sel_r, one;
  logic p_bl, a_bl, pend, wrap, boundary, on, blank, dp_r, fd_r;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [6:0] seg_r, dec;
  // slot position decode and pattern of the digit currently addressed by idx
  always_comb begin
    wrap = cnt == CMAX;
    boundary = bus.enable && wrap && idx == LAST;
    on = bus.enable && cnt >= CGRD;
    sh = a_val >> {idx, 2'b00};
    blank = a_bl && idx != '0 && sh == '0;
    dec = blank ? 7'h00 : LUT[sh[3:0]];
    one = DIGITS'(1) << idx;
  end
  // pending/active buffers swap only at frame boundaries, or freely while dark
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_val <= '0;
      p_dp <= '0;
      p_bl <= 1'b0;
      a_val <= '0;
      a_dp <= '0;
      a_bl <= 1'b0;
      pend <= 1'b0;
      cnt <= '0;
      idx <= '0;
    end else begin
      if (bus.load) begin
        p_val <= bus.value;
        p_dp <= bus.dp_in;
        p_bl <= bus.blank_lz;
      end
      if (!bus.enable || (boundary && pend)) begin
        a_val <= p_val;
        a_dp <= p_dp;
        a_bl <= p_bl;
      end
      pend <= bus.load || (pend && bus.enable && !boundary);
      cnt <= (!bus.enable || wrap) ? '0 : cnt + 1'b1;
      idx <= (!bus.enable || boundary) ? '0 : wrap ? idx + 1'b1 : idx;
    end
  // polarity-adjusted outputs, registered one cycle behind cnt/idx
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seg_r <= {7{INV}};
      dp_r <= INV;
      sel_r <= {DIGITS{INV}};
      fd_r <= 1'b0;
    end else begin
      seg_r <= (on ? dec : 7'h00) ^ {7{INV}};
      dp_r <= (on && a_dp[idx]) ^ INV;
      sel_r <= (on ? one : '0) ^ {DIGITS{INV}};
      fd_r <= boundary;
    end
  assign bus.seg = seg_r;
  assign bus.dp_out = dp_r;
  assign bus.dig_sel = sel_r;
  assign bus.frame_done = fd_r;
endmodule

// File: tb/tb_hex_scan_display.sv
// tb_hex_scan_display: random and directed checks of hex_scan_display against a frame-position model
module tb_hex_scan_display;
  localparam int D = 4, P = 8, G = 2;
  logic clk, rst_n, enable, load, blank_lz;
  logic [15:0] value;
  logic [3:0] dp_in;
  int total = 0, bad = 0;
  hex_scan_if #(.DIGITS(D)) b0();
  hex_scan_if #(.DIGITS(D)) b1();
  assign b0.enable = enable;
  assign b0.load = load;
  assign b0.value = value;
  assign b0.dp_in = dp_in;
  assign b0.blank_lz = blank_lz;
  assign b1.enable = enable;
  assign b1.load = load;
  assign b1.value = value;
  assign b1.dp_in = dp_in;
  assign b1.blank_lz = blank_lz;
  hex_scan_display #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .ACTIVE_LOW(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hex_scan_display #(.DIGITS(D), .PRESCALE(P), .GUARD(G), .ACTIVE_LOW(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  initial clk = 0;
  always #5 clk = ~clk;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  function automatic logic [6:0] mseg(input logic [15:0] v, input logic bl, input int d);
    logic [15:0] hi;
    hi = v >> (4 * d);
    if (bl && d != 0 && hi == 0) return 7'h00;
    return tbl[hi[3:0]];
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, got, want, $time);
    end
  endtask
  // model: position within the frame plus pending/active copies of the loaded data
  int m_pos;
  logic [15:0] m_av, m_pv;
  logic [3:0] m_ad, m_pd, e_sel, e_seln;
  logic m_ab, m_pb, m_pf, e_dp, e_dpn, e_fd;
  logic [6:0] e_seg, e_segn;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos = 0; m_av = 0; m_pv = 0; m_ad = 0; m_pd = 0;
      m_ab = 0; m_pb = 0; m_pf = 0;
      e_sel = 0; e_seg = 0; e_dp = 0; e_fd = 0;
    end else begin
      int d, s;
      d = m_pos / P;
      s = m_pos % P;
      e_sel = (enable && s >= G) ? 4'(1 << d) : 4'd0;
      e_seg = mseg(m_av, m_ab, d);
      e_dp = enable && s >= G && m_ad[d];
      e_fd = enable && m_pos == D * P - 1;
      if (!enable || m_pos == D * P - 1) begin
        if (m_pf) begin m_av = m_pv; m_ad = m_pd; m_ab = m_pb; end
        m_pf = 0;
        m_pos = 0;
      end else m_pos++;
      if (load) begin m_pv = value; m_pd = dp_in; m_pb = blank_lz; m_pf = 1; end
    end
    e_seln = ~e_sel;
    e_segn = ~e_seg;
    e_dpn = ~e_dp;
  end
  // every-cycle comparison of both polarities against the model
  always @(negedge clk) begin
    chk("sel", b0.dig_sel, e_sel);
    chk("sel_n", b1.dig_sel, e_seln);
    chk("fd", b0.frame_done, e_fd);
    chk("fd_n", b1.frame_done, e_fd);
    if (e_sel != 0) begin
      chk("seg", b0.seg, e_seg);
      chk("seg_n", b1.seg, e_segn);
      chk("dp", b0.dp_out, e_dp);
      chk("dp_n", b1.dp_out, e_dpn);
    end
  end
  logic [3:0] l_sel [64], l_sel1 [64];
  logic [6:0] l_seg [64];
  logic l_fd [64], l_dp1 [64];
  task automatic capture(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      l_sel[k] = b0.dig_sel; l_sel1[k] = b1.dig_sel; l_seg[k] = b0.seg;
      l_fd[k] = b0.frame_done; l_dp1[k] = b1.dp_out;
    end
  endtask
  task automatic run_frame(input logic [15:0] v, input logic [3:0] dp, input logic bl);
    @(negedge clk);
    enable = 0; load = 1; value = v; dp_in = dp; blank_lz = bl;
    @(negedge clk);
    load = 0;
    @(negedge clk);
    enable = 1;
    capture(32);
  endtask
  logic [15:0] masks [4] = '{16'h0000, 16'h000F, 16'h00FF, 16'hFFFF};
  initial begin
    rst_n = 0; enable = 0; load = 0; value = 0; dp_in = 0; blank_lz = 0;
    #12;
    chk("rst_sel", b0.dig_sel, 4'h0);
    chk("rst_sel_n", b1.dig_sel, 4'hF);
    chk("rst_seg_n", b1.seg, 7'h7F);
    chk("rst_dp_n", b1.dp_out, 1'b1);
    @(negedge clk);
    rst_n = 1;
    run_frame(16'h12AF, 4'h0, 1'b0);
    chk("f1_guard0", l_sel[0], 4'h0);
    chk("f1_guard1", l_sel[1], 4'h0);
    chk("f1_d0_sel", l_sel[2], 4'h1);
    chk("f1_d0_seg", l_seg[2], 7'h71);
    chk("f1_d0_end", l_sel[7], 4'h1);
    chk("f1_d1_guard", l_sel[8], 4'h0);
    chk("f1_d1_sel", l_sel[10], 4'h2);
    chk("f1_d1_seg", l_seg[10], 7'h77);
    chk("f1_d2_sel", l_sel[18], 4'h4);
    chk("f1_d2_seg", l_seg[18], 7'h5B);
    chk("f1_d3_sel", l_sel[26], 4'h8);
    chk("f1_d3_seg", l_seg[26], 7'h06);
    chk("f1_fd_early", l_fd[30], 1'b0);
    chk("f1_fd", l_fd[31], 1'b1);
    run_frame(16'h0005, 4'h0, 1'b1);
    chk("lz5_d0", l_seg[2], 7'h6D);
    chk("lz5_d1", l_seg[10], 7'h00);
    chk("lz5_d1_sel", l_sel[10], 4'h2);
    chk("lz5_d3", l_seg[26], 7'h00);
    run_frame(16'h0000, 4'h0, 1'b1);
    chk("lz0_d0", l_seg[2], 7'h3F);
    chk("lz0_d2", l_seg[18], 7'h00);
    run_frame(16'h0000, 4'b0100, 1'b1);
    chk("dpn_d2", l_dp1[18], 1'b0);
    chk("dpn_d0", l_dp1[2], 1'b1);
    chk("dpn_sel", l_sel1[18], 4'b1011);
    run_frame(16'h8888, 4'h0, 1'b0);
    load = 1; value = 16'h1111;
    @(negedge clk);
    value = 16'h2222;
    @(negedge clk);
    load = 0;
    capture(62);
    chk("mid_keep_seg", l_seg[8], 7'h7F);
    chk("mid_keep_sel", l_sel[8], 4'h2);
    chk("mid_fd_pre", l_fd[28], 1'b0);
    chk("mid_fd", l_fd[29], 1'b1);
    chk("mid_new_seg", l_seg[32], 7'h5B);
    chk("mid_new_sel", l_sel[32], 4'h1);
    chk("mid_fd2", l_fd[61], 1'b1);
    repeat (31) @(negedge clk);
    load = 1; value = 16'h3333;
    @(negedge clk);
    load = 0;
    capture(64);
    chk("bnd_old", l_seg[2], 7'h5B);
    chk("bnd_fd", l_fd[31], 1'b1);
    chk("bnd_new", l_seg[34], 7'h4F);
    repeat (5) @(negedge clk);
    enable = 0;
    @(negedge clk);
    chk("en_off_sel", b0.dig_sel, 4'h0);
    chk("en_off_sel_n", b1.dig_sel, 4'hF);
    enable = 1;
    capture(3);
    chk("en_on_guard", l_sel[0], 4'h0);
    chk("en_on_d0", l_sel[2], 4'h1);
    repeat (2) @(negedge clk);
    #3 rst_n = 0;
    #1;
    chk("arst_sel", b0.dig_sel, 4'h0);
    chk("arst_sel_n", b1.dig_sel, 4'hF);
    chk("arst_seg_n", b1.seg, 7'h7F);
    @(negedge clk);
    rst_n = 1;
    capture(3);
    chk("arst_guard", l_sel[0], 4'h0);
    chk("arst_d0", l_sel[2], 4'h1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load = $urandom_range(0, 9) == 0;
      value = 16'($urandom) & masks[$urandom_range(0, 3)];
      dp_in = 4'($urandom);
      blank_lz = 1'($urandom);
      if ($urandom_range(0, 99) == 0) enable = !enable;
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 0;
        #2 rst_n = 1;
      end
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
